// File: rtl/bicintp_cal2d_if.sv
// Stream bundle for bicintp_cal2d: per-row input beats in, packed output pixels out.
interface bicintp_cal2d_if #(
  parameter int unsigned CH_NUM = 3,
  parameter int unsigned CH_W   = 8,
  parameter int unsigned COEF_W = 8
);
  logic                     in_vld;
  logic                     in_rdy;
  logic                     in_row0;
  logic                     in_last;
  logic [4*CH_NUM*CH_W-1:0] in_pix;
  logic [4*COEF_W-1:0]      in_wx;
  logic [COEF_W-1:0]        in_wy;
  logic                     out_vld;
  logic                     out_rdy;
  logic [CH_NUM*CH_W-1:0]   out_data;
  logic                     out_last;

  modport master (
    output in_vld, in_row0, in_last, in_pix, in_wx, in_wy, out_rdy,
    input  in_rdy, out_vld, out_data, out_last
  );

  modport slave (
    input  in_vld, in_row0, in_last, in_pix, in_wx, in_wy, out_rdy,
    output in_rdy, out_vld, out_data, out_last
  );
endinterface

// File: rtl/bicintp_cal2d.sv
// 2D 4x4 bicubic pixel engine: horizontal MAC, vertical accumulate, round/clamp.
// Define BICINTP_SAT_CNT_EN to build the saturation event counter on sat_cnt.
module bicintp_cal2d #(
  parameter int unsigned CH_NUM = 3,
  parameter int unsigned CH_W   = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned FRAC   = 6
) (
  input  logic                sys_clk,
  input  logic                sys_rstn,
  bicintp_cal2d_if.slave      bus,
  output logic                sync_err,
  output logic [15:0]         sat_cnt
);
  localparam int unsigned H_W   = CH_W + COEF_W + 3;
  localparam int unsigned ACC_W = CH_W + 2 * COEF_W + 6;
  localparam int unsigned SHIFT = 2 * FRAC;
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(2 ** (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** CH_W - 1);

  typedef enum logic [1:0] {R0, R1, R2, R3} row_e;

  row_e r_row, w_row_eff, w_row_nxt;
  logic w_stall, w_acc, w_resync;
  logic r_sync_err;

  // Stage 1 registers
  logic                     r_s1_vld, r_s1_first, r_s1_final, r_s1_last;
  logic signed [COEF_W-1:0] r_s1_wy;
  logic signed [H_W-1:0]    r_s1_h [CH_NUM];
  logic signed [H_W-1:0]    w_h    [CH_NUM];

  // Stage 2 registers
  logic                     r_s2_vld, r_s2_last;
  logic signed [ACC_W-1:0]  r_acc     [CH_NUM];
  logic signed [ACC_W-1:0]  w_prod    [CH_NUM];
  logic signed [ACC_W-1:0]  w_acc_nxt [CH_NUM];

  // Stage 3
  logic signed [ACC_W-1:0]  w_rnd [CH_NUM];
  logic signed [ACC_W-1:0]  w_y   [CH_NUM];
  logic [CH_NUM*CH_W-1:0]   w_out_data;
  logic                     w_sat;
  logic                     r_out_vld, r_out_last;
  logic [CH_NUM*CH_W-1:0]   r_out_data;

  assign w_stall      = r_out_vld && !bus.out_rdy;
  assign bus.in_rdy   = sys_rstn && !w_stall;
  assign w_acc        = bus.in_vld && bus.in_rdy;
  assign bus.out_vld  = r_out_vld;
  assign bus.out_data = r_out_data;
  assign bus.out_last = r_out_last;
  assign sync_err     = r_sync_err;

  // Row sequencer
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_row <= R0;
    end else begin
      r_row <= w_row_nxt;
    end
  end

  always_comb begin
    w_row_eff = r_row;
    w_row_nxt = r_row;
    w_resync  = 1'b0;
    // A row-0 marker always restarts the group, dropping any partial sum.
    if (bus.in_row0) begin
      w_row_eff = R0;
    end
    if (w_acc) begin
      w_resync = bus.in_row0 && (r_row != R0);
      case (w_row_eff)
        R0:      w_row_nxt = R1;
        R1:      w_row_nxt = R2;
        R2:      w_row_nxt = R3;
        default: w_row_nxt = R0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_sync_err <= 1'b0;
    end else if (w_resync) begin
      r_sync_err <= 1'b1;
    end
  end

  // Stage 1: horizontal 4-tap MAC per channel
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      w_h[c] = '0;
      for (int i = 0; i < 4; i++) begin
        w_h[c] = w_h[c]
               + H_W'($signed({1'b0, bus.in_pix[(i*CH_NUM+c)*CH_W +: CH_W]}))
               * H_W'($signed(bus.in_wx[i*COEF_W +: COEF_W]));
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_final <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_wy    <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        r_s1_h[c] <= '0;
      end
    end else if (!w_stall) begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_first <= (w_row_eff == R0);
        r_s1_final <= (w_row_eff == R3);
        r_s1_last  <= bus.in_last;
        r_s1_wy    <= bus.in_wy;
        for (int c = 0; c < CH_NUM; c++) begin
          r_s1_h[c] <= w_h[c];
        end
      end
    end
  end

  // Stage 2: vertical accumulate; r_acc doubles as the stage-3 operand
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      w_prod[c]    = ACC_W'(r_s1_h[c]) * ACC_W'(r_s1_wy);
      w_acc_nxt[c] = r_s1_first ? w_prod[c] : (r_acc[c] + w_prod[c]);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        r_acc[c] <= '0;
      end
    end else if (!w_stall) begin
      r_s2_vld <= r_s1_vld && r_s1_final;
      if (r_s1_vld) begin
        if (r_s1_final) begin
          r_s2_last <= r_s1_last;
        end
        for (int c = 0; c < CH_NUM; c++) begin
          r_acc[c] <= w_acc_nxt[c];
        end
      end
    end
  end

  // Stage 3: round half up, drop 2*FRAC fraction bits, clamp to pixel range
  always_comb begin
    w_sat      = 1'b0;
    w_out_data = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      w_rnd[c] = r_acc[c] + RND;
      w_y[c]   = w_rnd[c] >>> SHIFT;
      if (w_y[c] < 0) begin
        w_sat = 1'b1;
      end else if (w_y[c] > MAXV) begin
        w_out_data[c*CH_W +: CH_W] = '1;
        w_sat = 1'b1;
      end else begin
        w_out_data[c*CH_W +: CH_W] = w_y[c][CH_W-1:0];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else if (!w_stall) begin
      r_out_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_out_data <= w_out_data;
        r_out_last <= r_s2_last;
      end
    end
  end

`ifdef BICINTP_SAT_CNT_EN
  logic        r_out_sat;
  logic [15:0] r_sat_cnt;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_out_sat <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      if (!w_stall && r_s2_vld) begin
        r_out_sat <= w_sat;
      end
      if (r_out_vld && bus.out_rdy && r_out_sat && (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end

  assign sat_cnt = r_sat_cnt;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_sat;
  assign sat_cnt      = '0;
`endif

endmodule

// File: tb/tb_bicintp_cal2d.sv
// Directed bench for bicintp_cal2d: identity, clamp, rounding, backpressure, resync, reset.
module tb_bicintp_cal2d;
  localparam int PIX_W = 96;
  localparam int WX_W  = 32;
  localparam int OUT_W = 24;
`ifdef BICINTP_SAT_CNT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic        sys_clk  = 1'b0;
  logic        sys_rstn = 1'b0;
  logic        sync_err;
  logic [15:0] sat_cnt;

  bicintp_cal2d_if #(.CH_NUM(3), .CH_W(8), .COEF_W(8)) bus ();

  bicintp_cal2d #(
    .CH_NUM (3),
    .CH_W   (8),
    .COEF_W (8),
    .FRAC   (6)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .bus      (bus),
    .sync_err (sync_err),
    .sat_cnt  (sat_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc;

  logic [OUT_W-1:0] obs_data [$];
  logic             obs_last [$];
  int               obs_cyc  [$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output monitor samples just before the active edge, after input drives settle.
  always begin
    @(negedge sys_clk);
    #4;
    if (sys_rstn && bus.out_vld && bus.out_rdy) begin
      obs_data.push_back(bus.out_data);
      obs_last.push_back(bus.out_last);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [PIX_W-1:0] mkpix(input logic [7:0] t0, input logic [7:0] t1,
                                             input logic [7:0] t2, input logic [7:0] t3);
    logic [7:0]       t [4];
    logic [PIX_W-1:0] p;
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        p[(i*3+c)*8 +: 8] = t[i];
      end
    end
    return p;
  endfunction

  function automatic logic [WX_W-1:0] mkwx(input logic [7:0] w0, input logic [7:0] w1,
                                           input logic [7:0] w2, input logic [7:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic clear_obs();
    obs_data.delete();
    obs_last.delete();
    obs_cyc.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic send_beat(input logic row0, input logic last, input logic [PIX_W-1:0] pix,
                           input logic [WX_W-1:0] wx, input logic [7:0] wy);
    int  t;
    bit  done;
    bus.in_vld  = 1'b1;
    bus.in_row0 = row0;
    bus.in_last = last;
    bus.in_pix  = pix;
    bus.in_wx   = wx;
    bus.in_wy   = wy;
    t    = 0;
    done = 1'b0;
    while (!done) begin
      #4;
      if (bus.in_rdy) begin
        done = 1'b1;
      end else begin
        t++;
        if (t >= 100) begin
          n_vec++;
          n_err++;
          $display("FAIL beat_accept_timeout: in_rdy=%0b after %0d cycles, required 1", bus.in_rdy, t);
          done = 1'b1;
        end
        @(negedge sys_clk);
      end
    end
    acc_cyc = cyc;
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    bus.in_vld  = 1'b0;
    bus.in_row0 = 1'b0;
    bus.in_last = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  // Four rows share taps and horizontal weights; only row 1 carries a vertical weight.
  task automatic send_grp1(input logic [PIX_W-1:0] pix, input logic [WX_W-1:0] wx,
                           input logic [7:0] wy1, input logic last);
    for (int r = 0; r < 4; r++) begin
      send_beat((r == 0), (r == 3) ? last : 1'b0, pix, wx, (r == 1) ? wy1 : 8'd0);
    end
  endtask

  task automatic test_reset();
    bus.in_vld  = 1'b0;
    bus.in_row0 = 1'b0;
    bus.in_last = 1'b0;
    bus.in_pix  = '0;
    bus.in_wx   = '0;
    bus.in_wy   = '0;
    bus.out_rdy = 1'b1;
    sys_rstn    = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    n_vec++; if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL rst_in_rdy: got %0b, want 0", bus.in_rdy); end
    n_vec++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL rst_out_vld: got %0b, want 0", bus.out_vld); end
    n_vec++; if (bus.out_data !== 24'h0) begin n_err++; $display("FAIL rst_out_data: got %h, want 0", bus.out_data); end
    n_vec++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %0b, want 0", bus.out_last); end
    n_vec++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL rst_sync_err: got %0b, want 0", sync_err); end
    n_vec++; if (sat_cnt !== 16'h0) begin n_err++; $display("FAIL rst_sat_cnt: got %0d, want 0", sat_cnt); end
    @(negedge sys_clk);
    sys_rstn = 1'b1;
    #1;
    n_vec++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL post_rst_in_rdy: got %0b, want 1", bus.in_rdy); end
    @(negedge sys_clk);
  endtask

  task automatic test_identity();
    int               r3;
    logic [PIX_W-1:0] p;
    clear_obs();
    send_grp1(mkpix(8'd100, 8'd100, 8'd100, 8'd100), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64, 1'b1);
    r3 = acc_cyc;
    idle(8);
    n_vec++; if (obs_data.size() !== 1) begin n_err++; $display("FAIL ident_count: got %0d, want 1", obs_data.size()); end
    if (obs_data.size() > 0) begin
      n_vec++; if (obs_data[0] !== {3{8'd100}}) begin n_err++; $display("FAIL ident_data: got %h, want %h", obs_data[0], {3{8'd100}}); end
      n_vec++; if (obs_last[0] !== 1'b1) begin n_err++; $display("FAIL ident_last: got %0b, want 1", obs_last[0]); end
      n_vec++; if (obs_cyc[0] - r3 !== 3) begin n_err++; $display("FAIL ident_latency: got %0d, want 3", obs_cyc[0] - r3); end
    end
    // Distinct channel values on tap 2 of row 2; every other row/tap weight is zero.
    clear_obs();
    p = mkpix(8'd255, 8'd255, 8'd255, 8'd255);
    p[(2*3+0)*8 +: 8] = 8'd10;
    p[(2*3+1)*8 +: 8] = 8'd50;
    p[(2*3+2)*8 +: 8] = 8'd90;
    send_beat(1'b1, 1'b0, p, mkwx(8'd0, 8'd0, 8'd64, 8'd0), 8'd0);
    send_beat(1'b0, 1'b0, p, mkwx(8'd0, 8'd0, 8'd64, 8'd0), 8'd0);
    send_beat(1'b0, 1'b0, p, mkwx(8'd0, 8'd0, 8'd64, 8'd0), 8'd64);
    send_beat(1'b0, 1'b0, p, mkwx(8'd0, 8'd0, 8'd64, 8'd0), 8'd0);
    idle(8);
    n_vec++; if (obs_data.size() !== 1) begin n_err++; $display("FAIL chan_count: got %0d, want 1", obs_data.size()); end
    if (obs_data.size() > 0) begin
      n_vec++; if (obs_data[0] !== {8'd90, 8'd50, 8'd10}) begin n_err++; $display("FAIL chan_data: got %h, want 5a320a", obs_data[0]); end
    end
  endtask

  task automatic test_clamp();
    clear_obs();
    send_grp1(mkpix(8'd0, 8'd255, 8'd255, 8'd0), mkwx(-8'sd8, 8'sd40, 8'sd40, -8'sd8), 8'd64, 1'b0);
    idle(8);
    n_vec++; if (obs_data.size() !== 1) begin n_err++; $display("FAIL over_count: got %0d, want 1", obs_data.size()); end
    if (obs_data.size() > 0) begin
      n_vec++; if (obs_data[0] !== {3{8'd255}}) begin n_err++; $display("FAIL over_data: got %h, want ffffff", obs_data[0]); end
    end
    n_vec++; if (sat_cnt !== (SatEn ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL over_sat_cnt: got %0d, want %0d", sat_cnt, SatEn ? 1 : 0); end
    clear_obs();
    send_grp1(mkpix(8'd255, 8'd0, 8'd0, 8'd255), mkwx(-8'sd8, 8'sd40, 8'sd40, -8'sd8), 8'd64, 1'b0);
    idle(8);
    n_vec++; if (obs_data.size() !== 1) begin n_err++; $display("FAIL under_count: got %0d, want 1", obs_data.size()); end
    if (obs_data.size() > 0) begin
      n_vec++; if (obs_data[0] !== 24'h0) begin n_err++; $display("FAIL under_data: got %h, want 000000", obs_data[0]); end
    end
    n_vec++; if (sat_cnt !== (SatEn ? 16'd2 : 16'd0)) begin n_err++; $display("FAIL under_sat_cnt: got %0d, want %0d", sat_cnt, SatEn ? 2 : 0); end
  endtask

  task automatic test_rounding();
    clear_obs();
    send_grp1(mkpix(8'd3, 8'd3, 8'd3, 8'd3), mkwx(8'd0, 8'd32, 8'd0, 8'd0), 8'd32, 1'b0);
    send_grp1(mkpix(8'd1, 8'd1, 8'd1, 8'd1), mkwx(8'd0, 8'd32, 8'd0, 8'd0), 8'd32, 1'b0);
    send_grp1(mkpix(8'd2, 8'd2, 8'd2, 8'd2), mkwx(8'd0, 8'd32, 8'd0, 8'd0), 8'd32, 1'b0);
    idle(8);
    n_vec++; if (obs_data.size() !== 3) begin n_err++; $display("FAIL round_count: got %0d, want 3", obs_data.size()); end
    if (obs_data.size() == 3) begin
      n_vec++; if (obs_data[0] !== {3{8'd1}}) begin n_err++; $display("FAIL round_3072: got %h, want 010101", obs_data[0]); end
      n_vec++; if (obs_data[1] !== 24'h0) begin n_err++; $display("FAIL round_1024: got %h, want 000000", obs_data[1]); end
      n_vec++; if (obs_data[2] !== {3{8'd1}}) begin n_err++; $display("FAIL round_half: got %h, want 010101", obs_data[2]); end
    end
    n_vec++; if (sat_cnt !== (SatEn ? 16'd2 : 16'd0)) begin n_err++; $display("FAIL round_sat_cnt: got %0d, want %0d", sat_cnt, SatEn ? 2 : 0); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    bus.out_rdy = 1'b1;
    fork
      begin
        send_grp1(mkpix(8'd10, 8'd10, 8'd10, 8'd10), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64, 1'b1);
        send_grp1(mkpix(8'd20, 8'd20, 8'd20, 8'd20), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64, 1'b0);
        send_grp1(mkpix(8'd30, 8'd30, 8'd30, 8'd30), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64, 1'b1);
        idle(0);
      end
      begin
        int               t;
        logic [OUT_W-1:0] held;
        t = 0;
        while (!bus.out_vld && t < 100) begin
          @(negedge sys_clk);
          t++;
        end
        n_vec++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL bp_first_result: out_vld=%0b, want 1", bus.out_vld); end
        bus.out_rdy = 1'b0;
        held = bus.out_data;
        n_vec++; if (held !== {3{8'd10}}) begin n_err++; $display("FAIL bp_first_data: got %h, want 0a0a0a", held); end
        for (int i = 0; i < 5; i++) begin
          #4;
          n_vec++; if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_rdy[%0d]: got %0b, want 0", i, bus.in_rdy); end
          n_vec++; if (bus.out_data !== held) begin n_err++; $display("FAIL bp_hold[%0d]: got %h, want %h", i, bus.out_data, held); end
          @(negedge sys_clk);
        end
        bus.out_rdy = 1'b1;
      end
    join
    idle(10);
    n_vec++; if (obs_data.size() !== 3) begin n_err++; $display("FAIL bp_count: got %0d, want 3", obs_data.size()); end
    if (obs_data.size() == 3) begin
      n_vec++; if (obs_data[0] !== {3{8'd10}}) begin n_err++; $display("FAIL bp_data0: got %h, want 0a0a0a", obs_data[0]); end
      n_vec++; if (obs_data[1] !== {3{8'd20}}) begin n_err++; $display("FAIL bp_data1: got %h, want 141414", obs_data[1]); end
      n_vec++; if (obs_data[2] !== {3{8'd30}}) begin n_err++; $display("FAIL bp_data2: got %h, want 1e1e1e", obs_data[2]); end
      n_vec++; if (obs_last[0] !== 1'b1) begin n_err++; $display("FAIL bp_last0: got %0b, want 1", obs_last[0]); end
      n_vec++; if (obs_last[1] !== 1'b0) begin n_err++; $display("FAIL bp_last1: got %0b, want 0", obs_last[1]); end
      n_vec++; if (obs_last[2] !== 1'b1) begin n_err++; $display("FAIL bp_last2: got %0b, want 1", obs_last[2]); end
    end
  endtask

  task automatic test_resync();
    clear_obs();
    send_beat(1'b1, 1'b0, mkpix(8'd200, 8'd200, 8'd200, 8'd200), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64);
    send_beat(1'b0, 1'b0, mkpix(8'd200, 8'd200, 8'd200, 8'd200), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64);
    n_vec++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL resync_pre_err: got %0b, want 0", sync_err); end
    send_grp1(mkpix(8'd77, 8'd77, 8'd77, 8'd77), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64, 1'b1);
    idle(8);
    n_vec++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL resync_err: got %0b, want 1", sync_err); end
    n_vec++; if (obs_data.size() !== 1) begin n_err++; $display("FAIL resync_count: got %0d, want 1", obs_data.size()); end
    if (obs_data.size() > 0) begin
      n_vec++; if (obs_data[0] !== {3{8'd77}}) begin n_err++; $display("FAIL resync_data: got %h, want 4d4d4d", obs_data[0]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_beat(1'b1, 1'b0, mkpix(8'd200, 8'd200, 8'd200, 8'd200), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64);
    send_beat(1'b0, 1'b0, mkpix(8'd200, 8'd200, 8'd200, 8'd200), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64);
    bus.in_vld = 1'b0;
    sys_rstn   = 1'b0;
    @(negedge sys_clk);
    sys_rstn = 1'b1;
    n_vec++; if (sat_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_sat_cnt: got %0d, want 0", sat_cnt); end
    send_grp1(mkpix(8'd55, 8'd55, 8'd55, 8'd55), mkwx(8'd0, 8'd64, 8'd0, 8'd0), 8'd64, 1'b0);
    idle(8);
    n_vec++; if (obs_data.size() !== 1) begin n_err++; $display("FAIL midrst_count: got %0d, want 1", obs_data.size()); end
    if (obs_data.size() > 0) begin
      n_vec++; if (obs_data[0] !== {3{8'd55}}) begin n_err++; $display("FAIL midrst_data: got %h, want 373737", obs_data[0]); end
    end
    n_vec++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL midrst_sync_err: got %0b, want 0", sync_err); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_clamp();
    test_rounding();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bicintp_cal2d.md
Name: bicintp_cal2d

Overview:
- Parametrised successor to the bicubic calculation stage.
- Computes one full 2D 4x4 bicubic output pixel per group of four input beats. Each beat carries one source row: 4 taps and 4 horizontal weights for that row, plus 1 vertical weight.
- Supports multiple packed colour channels, signed fixed-point weights, rounding/clamping and valid/ready backpressure.
- Sits between the line-buffer/ROM front end and the DDR write path.

Parameters:
- CH_NUM, 3, number of packed colour channels; all channels share the same weights.
- CH_W, 8, unsigned bits per channel.
- COEF_W, 8, signed two's-complement weight width.
- FRAC, 6, fractional bits per weight; unity weight = 2^FRAC.

Ports:
- sys_clk  in  1  single clock for the block.
- sys_rstn  in  1  asynchronous active-low reset.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  block can accept a beat.
- in_row0  in  1  marks the row-0 beat of a group.
- in_last  in  1  tag carried to the output; sampled on the row-3 beat.
- in_pix  in  4*CH_NUM*CH_W  tap i, channel c at bits [(i*CH_NUM+c)*CH_W +: CH_W].
- in_wx  in  4*COEF_W  horizontal weight i at bits [i*COEF_W +: COEF_W].
- in_wy  in  COEF_W  vertical weight for this row.
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts.
- out_data  out  CH_NUM*CH_W  result; channel c at bits [c*CH_W +: CH_W].
- out_last  out  1  in_last of the group's row-3 beat.
- sync_err  out  1  sticky row-sequence error flag.
- sat_cnt  out  16  saturation event count (see Optional Feature).

Behaviour:
- Reset values: in_rdy=0 while in reset, 1 after; out_vld=0, out_data=0, out_last=0, sync_err=0, sat_cnt=0, row_cnt=0, accumulators=0, pipeline valids=0.
- Accept: a beat is accepted when in_vld && in_rdy.
- Stall: stall = out_vld && !out_rdy; in_rdy = !stall. The whole pipeline freezes during stall; no stage advances or drops data.
- Row state machine: row_cnt states R0..R3, one step per accepted beat.
  - R3 -> R0 on accept and emits the group.
  - An accepted beat with in_row0=1 while row_cnt!=R0: set sync_err; discard the partial accumulation; treat the beat as R0; next state R1.
  - in_row0=0 in R0 is accepted as row 0 without error.
- Stage 1 (registered), per channel: h = sum_i(pix_i * wx_i). Signed, width CH_W+COEF_W+3, no truncation.
- Stage 2 (registered), per channel: acc = (row==R0 ? 0 : acc) + h*wy. Signed, width CH_W+2*COEF_W+6, full precision.
  - On the R3 result, the final acc is handed to stage 3.
- Stage 3 (output register), per channel: y = (acc + 2^(2*FRAC-1)) >>> (2*FRAC) (arithmetic shift), then clamp.
  - y<0 -> 0; y>2^CH_W-1 -> 2^CH_W-1.
  - A group is saturated if any channel clamps.
- Latency: out_vld rises 3 cycles after the R3 beat is accepted, excluding stall cycles.
- Output hold: out_data and out_last are held stable while out_vld && !out_rdy.
- Throughput: 1 beat/cycle when unstalled, i.e. 1 output per 4 cycles.
- Reset mid-group: asserting sys_rstn low at any time clears the partial group and all pending results; the first accepted beat after reset is row 0.
- sync_err clears only on reset.

Optional Feature:
- Macro: BICINTP_SAT_CNT_EN.
- Defined: sat_cnt increments by 1 on each output handshake (out_vld && out_rdy) whose group saturated. It saturates at 16'hFFFF with no wrap.
- Undefined: the counter logic is absent and sat_cnt is tied to 0.

Test Plan (CH_NUM=3, CH_W=8, COEF_W=8, FRAC=6, out_rdy=1 unless stated):
- Identity: all pix=100, wx={0,64,0,0}, wy row1=64 and others 0 -> out_data={100,100,100}, out_vld 3 cycles after the R3 beat.
- Overshoot and undershoot clamp:
  - row1 taps {0,255,255,0}, wx={-8,40,40,-8}, wy row1=64 -> 255 (exact value 318.75). sat_cnt=1 when BICINTP_SAT_CNT_EN is defined, else 0.
  - taps {255,0,0,255} with the same weights -> 0 (exact value -63.75). sat_cnt=2 when defined.
- Rounding: all pix=3, wx={0,32,0,0}, wy row1=32 -> acc=3072 -> out=1. All pix=1 with the same weights -> out=0.
- Backpressure: stream 3 groups back to back; hold out_rdy=0 for 5 cycles when the first result appears.
  - in_rdy=0 and out_data stable throughout the stall.
  - All 3 results are delivered in order once out_rdy=1.
  - out_last matches each group's row-3 in_last.
- Resync: send beats with in_row0 pattern 1,0,1,0,0,0 -> sync_err=1; exactly one output, equal to the group beginning at the 3rd beat.
- Reset mid-group: send 2 beats, pulse sys_rstn low for 1 cycle, then one full group -> a single correct output; no residue from the first 2 beats; sync_err=0.
